mcu_scheduler: RTL and testbench

//  Sequences 8x8 coefficient blocks from the three per-component quantiser outputs
//  (Y, Cb, Cr) into the single shared zigzag/entropy stage.

---
 rtl/jpeg_pkg.sv | 32 +++
 rtl/mcu_scheduler.sv | 111 +++++++++++
 tb/tb_mcu_scheduler.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jpeg_pkg.sv
// Shared JPEG pipeline types: component ids, block size and the MCU block order.
package jpeg_pkg;

    typedef enum logic [1:0] {
        COMP_Y  = 2'd0,
        COMP_CB = 2'd1,
        COMP_CR = 2'd2
    } comp_t;

    localparam int BLOCK_BEATS = 64;

    // Component granted at schedule slot idx: 4:2:0 is Y Y Y Y Cb Cr, 4:4:4 is Y Cb Cr.
    function automatic comp_t sched_comp(input logic sub420, input logic [2:0] idx);
        comp_t c;
        c = COMP_Y;
        if (sub420) begin
            case (idx)
                3'd4:    c = COMP_CB;
                3'd5:    c = COMP_CR;
                default: c = COMP_Y;
            endcase
        end else begin
            case (idx)
                3'd1:    c = COMP_CB;
                3'd2:    c = COMP_CR;
                default: c = COMP_Y;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/mcu_scheduler.sv
// Grants Y/Cb/Cr quantiser outputs to the shared zigzag stage one 64-beat block at a
// time in MCU order, tags beats with block/MCU flags and pulses frame_done at frame end.
module mcu_scheduler
    import jpeg_pkg::*;
#(
    parameter int W     = 10,
    parameter int MCU_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_start,
    input  logic                sub420,
    input  logic [MCU_W-1:0]    num_mcus,
    input  logic [2:0]          src_ena,
    output logic [2:0]          src_rdy,
    input  logic [2:0][W-1:0]   src_data,
    output logic                ena_out,
    input  logic                rdy_in,
    output logic [W-1:0]        out,
    output comp_t               comp_id,
    output logic                blk_first,
    output logic                blk_last,
    output logic                mcu_last,
    output logic                busy,
    output logic                frame_done
);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    localparam logic [5:0] LAST_BEAT = 6'(BLOCK_BEATS - 1);

    state_t           state, state_nx;
    logic [5:0]       beat_cnt;
    logic [2:0]       sched_idx, last_idx;
    logic [MCU_W-1:0] mcu_cnt, mcu_inc, num_mcus_q;
    logic             sub420_q;
    logic             xfer, beat, blk_end, mcu_end, accept;

    assign xfer     = (state == XFER);
    assign accept   = (state == IDLE) && frame_start;
    assign last_idx = sub420_q ? 3'd5 : 3'd2;
    assign comp_id  = sched_comp(sub420_q, sched_idx);
    assign mcu_inc  = mcu_cnt + MCU_W'(1);

    // Grant mux: only the granted component sees rdy_in, everything is quiet outside XFER.
    always_comb begin
        src_rdy = '0;
        ena_out = 1'b0;
        out     = '0;
        if (xfer) begin
            case (comp_id)
                COMP_Y:  begin src_rdy[0] = rdy_in; ena_out = src_ena[0]; out = src_data[0]; end
                COMP_CB: begin src_rdy[1] = rdy_in; ena_out = src_ena[1]; out = src_data[1]; end
                COMP_CR: begin src_rdy[2] = rdy_in; ena_out = src_ena[2]; out = src_data[2]; end
                default: ;
            endcase
        end
    end

    assign beat    = ena_out & rdy_in;
    assign blk_end = beat && (beat_cnt == LAST_BEAT);
    assign mcu_end = blk_end && (sched_idx == last_idx);

    assign blk_first = xfer && (beat_cnt == 6'd0);
    assign blk_last  = xfer && (beat_cnt == LAST_BEAT);
    assign mcu_last  = xfer && (sched_idx == last_idx);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (frame_start) state_nx = (num_mcus == '0) ? DONE : XFER;
            XFER: if (mcu_end && (mcu_inc == num_mcus_q)) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            frame_done <= 1'b0;
            beat_cnt   <= '0;
            sched_idx  <= '0;
            mcu_cnt    <= '0;
            num_mcus_q <= '0;
            sub420_q   <= 1'b0;
        end else begin
            state      <= state_nx;
            frame_done <= (state_nx == DONE);
            if (accept) begin
                sub420_q   <= sub420;
                num_mcus_q <= num_mcus;
                beat_cnt   <= '0;
                sched_idx  <= '0;
                mcu_cnt    <= '0;
            end else if (beat) begin
                beat_cnt <= beat_cnt + 6'd1;
                if (blk_end) begin
                    if (mcu_end) begin
                        sched_idx <= '0;
                        mcu_cnt   <= mcu_inc;
                    end else begin
                        sched_idx <= sched_idx + 3'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mcu_scheduler.sv
// Randomised bench for mcu_scheduler against a queue-of-expected-beats model.
module tb_mcu_scheduler;
    import jpeg_pkg::*;

    localparam int W     = 10;
    localparam int MCU_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             frame_start = 1'b0;
    logic             sub420 = 1'b0;
    logic [MCU_W-1:0] num_mcus = '0;
    logic [2:0]       src_ena = '0;
    logic [2:0]       src_rdy;
    logic [2:0][W-1:0] src_data = '0;
    logic             ena_out;
    logic             rdy_in = 1'b0;
    logic [W-1:0]     out;
    comp_t            comp_id;
    logic             blk_first, blk_last, mcu_last, busy, frame_done;

    always #5 clk = ~clk;

    mcu_scheduler #(.W(W), .MCU_W(MCU_W)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .sub420(sub420),
        .num_mcus(num_mcus), .src_ena(src_ena), .src_rdy(src_rdy), .src_data(src_data),
        .ena_out(ena_out), .rdy_in(rdy_in), .out(out), .comp_id(comp_id),
        .blk_first(blk_first), .blk_last(blk_last), .mcu_last(mcu_last),
        .busy(busy), .frame_done(frame_done)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Sources: component c emits c*256 + (words accepted so far mod 256).
    int src_cnt[3] = '{0, 0, 0};
    bit rand_mode  = 1'b0;

    initial begin
        bit took[3];
        forever begin
            @(negedge clk);
            for (int c = 0; c < 3; c++) took[c] = src_rdy[c] & src_ena[c];
            @(posedge clk);
            #1;
            for (int c = 0; c < 3; c++) begin
                if (took[c]) src_cnt[c]++;
                src_data[c] = W'(c * 256 + (src_cnt[c] % 256));
                src_ena[c]  = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            rdy_in = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Model: on an accepted frame the whole frame is expanded into a queue of expected
    // beats; the head of the queue is the beat currently offered.
    typedef struct {
        int comp;
        int k;
        bit mlast;
    } beat_t;

    beat_t q[$];
    bit    m_done = 1'b0;
    int    mcnt[3] = '{0, 0, 0};
    int    beat_total  = 0;
    int    first_total = 0;
    int    seq[$];

    always @(negedge clk) begin
        bit    x;
        int    c;
        int    ord[$];
        beat_t b;
        if (rst) begin
            chk("rst_src_rdy", int'(src_rdy), 0);
            chk("rst_ena_out", int'(ena_out), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_frame_done", int'(frame_done), 0);
            chk("rst_out", int'(out), 0);
            chk("rst_comp_id", int'(comp_id), 0);
            chk("rst_flags", int'({blk_first, blk_last, mcu_last}), 0);
            q.delete();
            m_done = 1'b0;
        end else begin
            x = (q.size() != 0);
            c = x ? q[0].comp : 0;
            chk("src_rdy", int'(src_rdy), x ? (int'(rdy_in) << c) : 0);
            chk("src_rdy_onehot0", int'($onehot0(src_rdy)), 1);
            chk("ena_out", int'(ena_out), x ? int'(src_ena[c]) : 0);
            chk("out", int'(out), x ? (c * 256 + (mcnt[c] % 256)) : 0);
            chk("comp_id", int'(comp_id), c);
            chk("blk_first", int'(blk_first), x ? int'(q[0].k == 0) : 0);
            chk("blk_last", int'(blk_last), x ? int'(q[0].k == 63) : 0);
            chk("mcu_last", int'(mcu_last), x ? int'(q[0].mlast) : 0);
            chk("busy", int'(busy), int'(x || m_done));
            chk("frame_done", int'(frame_done), int'(m_done));
            // advance to what the coming edge does
            if (m_done) begin
                m_done = 1'b0;
            end else if (x) begin
                if (src_ena[c] && rdy_in) begin
                    beat_total++;
                    if (q[0].k == 0) begin
                        first_total++;
                        seq.push_back(c);
                    end
                    mcnt[c]++;
                    void'(q.pop_front());
                    if (q.size() == 0) m_done = 1'b1;
                end
            end else if (frame_start) begin
                if (sub420) ord = '{0, 0, 0, 0, 1, 2};
                else        ord = '{0, 1, 2};
                for (int m = 0; m < int'(num_mcus); m++)
                    for (int i = 0; i < ord.size(); i++)
                        for (int k = 0; k < BLOCK_BEATS; k++) begin
                            b.comp  = ord[i];
                            b.k     = k;
                            b.mlast = (i == ord.size() - 1);
                            q.push_back(b);
                        end
                if (num_mcus == '0) m_done = 1'b1;
            end
        end
    end

    task automatic clr_stats();
        beat_total  = 0;
        first_total = 0;
        seq.delete();
    endtask

    task automatic pulse();
        @(posedge clk);
        #1;
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
    endtask

    task automatic start(input bit s, input int n);
        @(posedge clk);
        #1;
        sub420      = s;
        num_mcus    = MCU_W'(n);
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int i;
        i = 0;
        while (!(q.size() == 0 && !m_done) && i < budget) begin
            @(posedge clk);
            #1;
            i++;
        end
        chk("wait_idle_in_budget", int'(i < budget), 1);
    endtask

    task automatic chk_seq(input string nm, input int exp[$]);
        chk({nm, "_len"}, seq.size(), exp.size());
        for (int i = 0; i < exp.size() && i < seq.size(); i++) chk(nm, seq[i], exp[i]);
    endtask

    initial begin
        int cyc;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_comp_id", int'(comp_id), int'(COMP_Y));
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // 4:4:4, two MCUs, no backpressure: frame_done 385 cycles after acceptance edge
        clr_stats();
        @(posedge clk);
        #1;
        sub420 = 1'b0; num_mcus = 16'd2; frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        cyc = 1;
        while (!frame_done && cyc < 1000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("t1_done_cycle", cyc, 385);
        wait_idle(100);
        chk("t1_beats", beat_total, 384);
        chk("t1_blocks", first_total, 6);
        chk_seq("t1_seq", '{0, 1, 2, 0, 1, 2});

        // 4:2:0, one MCU
        clr_stats();
        start(1'b1, 1);
        wait_idle(1000);
        chk("t2_beats", beat_total, 384);
        chk_seq("t2_seq", '{0, 0, 0, 0, 1, 2});

        // random backpressure, 4:2:0, three MCUs
        clr_stats();
        rand_mode = 1'b1;
        start(1'b1, 3);
        wait_idle(20000);
        chk("t3_beats", beat_total, 1152);
        chk("t3_blocks", first_total, 18);
        rand_mode = 1'b0;
        repeat (2) @(posedge clk);

        // empty frame: done in the cycle after acceptance, no beats
        clr_stats();
        start(1'b0, 0);
        chk("t4_empty_done", int'(frame_done), 1);
        chk("t4_empty_ena", int'(ena_out), 0);
        wait_idle(10);
        chk("t4_empty_beats", beat_total, 0);

        // frame_start while busy is ignored
        clr_stats();
        start(1'b0, 1);
        repeat (50) @(posedge clk);
        #1;
        sub420 = 1'b1; num_mcus = 16'd3; frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        wait_idle(1000);
        chk("t4_busy_start_beats", beat_total, 192);
        chk_seq("t4_seq", '{0, 1, 2});

        // reset at beat 30 of the second Y block
        clr_stats();
        start(1'b1, 1);
        repeat (94) @(posedge clk);
        #1;
        chk("t5_pre_beats", beat_total, 94);
        chk("t5_pre_comp", int'(comp_id), int'(COMP_Y));
        chk("t5_pre_first", int'(blk_first), 0);
        rst = 1'b1;
        #1;
        chk("t5_rst_src_rdy", int'(src_rdy), 0);
        chk("t5_rst_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        clr_stats();
        start(1'b0, 1);
        chk("t5_restart_first", int'(blk_first), 1);
        chk("t5_restart_comp", int'(comp_id), int'(COMP_Y));
        wait_idle(1000);
        chk("t5_restart_beats", beat_total, 192);

        // config changes mid-frame only apply to the next accepted frame
        clr_stats();
        start(1'b1, 2);
        repeat (100) @(posedge clk);
        #1;
        sub420 = 1'b0; num_mcus = 16'd1;
        wait_idle(2000);
        chk("t6_frame_beats", beat_total, 768);
        clr_stats();
        pulse();
        wait_idle(1000);
        chk("t6_next_beats", beat_total, 192);
        chk_seq("t6_next_seq", '{0, 1, 2});

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
